// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: carries the decoded controls and register indices through
// the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use and
// ID-stage branch hazards, produces the EX and ID forwarding selects, and
// resolves beq/bne/j in ID, which generates the IF/ID flush.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous, active-high reset
//   id_*               decoder controls, register fields and comparator result in ID
//   pc_write, ifid_write  0 = hold PC / IF/ID (stall)
//   ifid_flush         1 = IF/ID loads a nop (taken branch or jump)
//   branch_taken       beq/bne resolved taken in ID
//   ex_*               ID/EX control and indices; ex_dest is combinational
//   mem_*              EX/MEM control and destination
//   wb_*               MEM/WB control and destination (memtoreg 1 = ALU result)
//   fwd_a, fwd_b       EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   fwd_id_a, fwd_id_b ID comparator operand taken from the EX/MEM result
module ctrl_pipe_hazard #(
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_regdst,
  input  logic            id_brancheq,
  input  logic            id_branchne,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            id_alusrc,
  input  logic            id_regwrite,
  input  logic            id_jump,
  input  logic [1:0]      id_aluop,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_equal,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            branch_taken,
  output logic            ex_regdst,
  output logic            ex_alusrc,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_regwrite,
  output logic [1:0]      ex_aluop,
  output logic [RA_W-1:0] ex_rs,
  output logic [RA_W-1:0] ex_rt,
  output logic [RA_W-1:0] ex_rd,
  output logic [RA_W-1:0] ex_dest,
  output logic            mem_memread,
  output logic            mem_memwrite,
  output logic            mem_memtoreg,
  output logic            mem_regwrite,
  output logic [RA_W-1:0] mem_dest,
  output logic            wb_memtoreg,
  output logic            wb_regwrite,
  output logic [RA_W-1:0] wb_dest,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            fwd_id_a,
  output logic            fwd_id_b
);

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] aluop;
  } ex_ctl_t;

  ex_ctl_t         id_ctl;
  ex_ctl_t         idex_ctl_d, idex_ctl_q;
  logic [RA_W-1:0] idex_rs_q, idex_rt_q, idex_rd_q;
  logic            exmem_memread_q, exmem_memwrite_q, exmem_memtoreg_q, exmem_regwrite_q;
  logic [RA_W-1:0] exmem_dest_q;
  logic            memwb_memtoreg_q, memwb_regwrite_q;
  logic [RA_W-1:0] memwb_dest_q;

  logic id_branch, ex_hit, mem_hit, stall, taken;

  assign id_ctl = '{regdst:   id_regdst,   alusrc:   id_alusrc,
                    memread:  id_memread,  memwrite: id_memwrite,
                    memtoreg: id_memtoreg, regwrite: id_regwrite,
                    aluop:    id_aluop};

  // Stage register outputs
  assign ex_regdst    = idex_ctl_q.regdst;
  assign ex_alusrc    = idex_ctl_q.alusrc;
  assign ex_memread   = idex_ctl_q.memread;
  assign ex_memwrite  = idex_ctl_q.memwrite;
  assign ex_memtoreg  = idex_ctl_q.memtoreg;
  assign ex_regwrite  = idex_ctl_q.regwrite;
  assign ex_aluop     = idex_ctl_q.aluop;
  assign ex_rs        = idex_rs_q;
  assign ex_rt        = idex_rt_q;
  assign ex_rd        = idex_rd_q;
  assign ex_dest      = idex_ctl_q.regdst ? idex_rd_q : idex_rt_q;
  assign mem_memread  = exmem_memread_q;
  assign mem_memwrite = exmem_memwrite_q;
  assign mem_memtoreg = exmem_memtoreg_q;
  assign mem_regwrite = exmem_regwrite_q;
  assign mem_dest     = exmem_dest_q;
  assign wb_memtoreg  = memwb_memtoreg_q;
  assign wb_regwrite  = memwb_regwrite_q;
  assign wb_dest      = memwb_dest_q;

  // Hazard detection: index 0 is never a real dependency
  always_comb begin
    id_branch = id_brancheq | id_branchne;
    ex_hit    = (ex_dest != '0) && ((ex_dest == id_rs) || (ex_dest == id_rt));
    mem_hit   = (exmem_dest_q != '0) &&
                ((exmem_dest_q == id_rs) || (exmem_dest_q == id_rt));
    stall     = (idex_ctl_q.memread & ex_hit) |
                (id_branch & idex_ctl_q.regwrite & ex_hit) |
                (id_branch & exmem_memread_q & mem_hit);
    // A stalled branch must not redirect fetch; it re-resolves once operands are ready
    taken        = ~stall & ((id_brancheq & id_equal) | (id_branchne & ~id_equal));
    branch_taken = taken;
    ifid_flush   = ~stall & (taken | id_jump);
    pc_write     = ~stall;
    ifid_write   = ~stall;
  end

  // Bubble insertion: controls zeroed while stalled, indices still copied
  always_comb begin
    idex_ctl_d = id_ctl;
    if (stall) idex_ctl_d = '0;
  end

  // EX forwarding: the younger EX/MEM result has priority over MEM/WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (exmem_regwrite_q && (exmem_dest_q != '0) && (exmem_dest_q == idex_rs_q))
      fwd_a = 2'b10;
    else if (memwb_regwrite_q && (memwb_dest_q != '0) && (memwb_dest_q == idex_rs_q))
      fwd_a = 2'b01;
    if (exmem_regwrite_q && (exmem_dest_q != '0) && (exmem_dest_q == idex_rt_q))
      fwd_b = 2'b10;
    else if (memwb_regwrite_q && (memwb_dest_q != '0) && (memwb_dest_q == idex_rt_q))
      fwd_b = 2'b01;
  end

  // ID forwarding: only an ALU result in EX/MEM is available to the comparator
  always_comb begin
    fwd_id_a = exmem_regwrite_q & ~exmem_memread_q & (exmem_dest_q != '0) &
               (exmem_dest_q == id_rs);
    fwd_id_b = exmem_regwrite_q & ~exmem_memread_q & (exmem_dest_q != '0) &
               (exmem_dest_q == id_rt);
  end

  // Pipeline control registers; reset leaves a bubble in every stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_ctl_q       <= '0;
      idex_rs_q        <= '0;
      idex_rt_q        <= '0;
      idex_rd_q        <= '0;
      exmem_memread_q  <= 1'b0;
      exmem_memwrite_q <= 1'b0;
      exmem_memtoreg_q <= 1'b0;
      exmem_regwrite_q <= 1'b0;
      exmem_dest_q     <= '0;
      memwb_memtoreg_q <= 1'b0;
      memwb_regwrite_q <= 1'b0;
      memwb_dest_q     <= '0;
    end else begin
      idex_ctl_q       <= idex_ctl_d;
      idex_rs_q        <= id_rs;
      idex_rt_q        <= id_rt;
      idex_rd_q        <= id_rd;
      exmem_memread_q  <= idex_ctl_q.memread;
      exmem_memwrite_q <= idex_ctl_q.memwrite;
      exmem_memtoreg_q <= idex_ctl_q.memtoreg;
      exmem_regwrite_q <= idex_ctl_q.regwrite;
      exmem_dest_q     <= ex_dest;
      memwb_memtoreg_q <= exmem_memtoreg_q;
      memwb_regwrite_q <= exmem_regwrite_q;
      memwb_dest_q     <= exmem_dest_q;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench for ctrl_pipe_hazard: the stimulus pushes expected output
// values stamped with the cycle they apply to; a monitor pops and compares them
// on the falling edge of that cycle.
module tb_ctrl_pipe_hazard;
  localparam int unsigned RA_W = 5;

  logic clk = 1'b0;
  logic reset;
  logic id_regdst, id_brancheq, id_branchne, id_memread, id_memwrite;
  logic id_memtoreg, id_alusrc, id_regwrite, id_jump, id_equal;
  logic [1:0] id_aluop;
  logic [RA_W-1:0] id_rs, id_rt, id_rd;
  logic pc_write, ifid_write, ifid_flush, branch_taken;
  logic ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [1:0] ex_aluop;
  logic [RA_W-1:0] ex_rs, ex_rt, ex_rd, ex_dest;
  logic mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
  logic [RA_W-1:0] mem_dest;
  logic wb_memtoreg, wb_regwrite;
  logic [RA_W-1:0] wb_dest;
  logic [1:0] fwd_a, fwd_b;
  logic fwd_id_a, fwd_id_b;

  ctrl_pipe_hazard #(.RA_W(RA_W)) dut (
    .clk(clk), .reset(reset),
    .id_regdst(id_regdst), .id_brancheq(id_brancheq), .id_branchne(id_branchne),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_jump(id_jump),
    .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_equal(id_equal),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .branch_taken(branch_taken),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_aluop(ex_aluop), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_dest(ex_dest),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_dest(mem_dest),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_dest(wb_dest),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {S_PCW, S_IFW, S_FLUSH, S_BT, S_EXMR, S_EXRW, S_MEMRW,
                    S_WBRW, S_FWDA, S_FWDB, S_FIDA, S_FIDB, S_EXDEST} sel_t;
  typedef struct {
    int         cyc;
    sel_t       sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] sample(sel_t s);
    case (s)
      S_PCW:    return 8'(pc_write);
      S_IFW:    return 8'(ifid_write);
      S_FLUSH:  return 8'(ifid_flush);
      S_BT:     return 8'(branch_taken);
      S_EXMR:   return 8'(ex_memread);
      S_EXRW:   return 8'(ex_regwrite);
      S_MEMRW:  return 8'(mem_regwrite);
      S_WBRW:   return 8'(wb_regwrite);
      S_FWDA:   return 8'(fwd_a);
      S_FWDB:   return 8'(fwd_b);
      S_FIDA:   return 8'(fwd_id_a);
      S_FIDB:   return 8'(fwd_id_b);
      S_EXDEST: return 8'(ex_dest);
      default:  return 8'hxx;
    endcase
  endfunction

  // Monitor: every expectation is compared on the falling edge of its cycle
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      act = sample(e.sel);
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: expectation for cycle %0d reached monitor in cycle %0d",
                 e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        bad++;
        $display("FAIL %s: cycle %0d got %0h expected %0h", e.name, cyc, act, e.val);
      end
    end
  end

  task automatic exp_push(input sel_t s, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.sel = s; e.val = v; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic set_id(input logic regdst, brancheq, branchne, memread, memwrite,
                        memtoreg, alusrc, regwrite, jump,
                        input logic [1:0] aluop,
                        input logic [RA_W-1:0] rs, rt, rd,
                        input logic eq);
    id_regdst = regdst; id_brancheq = brancheq; id_branchne = branchne;
    id_memread = memread; id_memwrite = memwrite; id_memtoreg = memtoreg;
    id_alusrc = alusrc; id_regwrite = regwrite; id_jump = jump;
    id_aluop = aluop; id_rs = rs; id_rt = rt; id_rd = rd; id_equal = eq;
  endtask

  task automatic i_nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0);
  endtask
  task automatic i_alu(input logic [4:0] rd, rs, rt);
    set_id(1, 0, 0, 0, 0, 1, 0, 1, 0, 2'b10, rs, rt, rd, 0);
  endtask
  task automatic i_lw(input logic [4:0] rt, rs);
    set_id(0, 0, 0, 1, 0, 0, 1, 1, 0, 2'b00, rs, rt, 5'd0, 0);
  endtask
  task automatic i_beq(input logic [4:0] rs, rt, input logic eq);
    set_id(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, rs, rt, 5'd0, eq);
  endtask
  task automatic i_bne(input logic [4:0] rs, rt, input logic eq);
    set_id(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, rs, rt, 5'd0, eq);
  endtask
  task automatic i_j();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      i_nop();
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_nop();
    step();
    // Reset state
    exp_push(S_PCW, 8'd1, "rst_pcw");
    exp_push(S_IFW, 8'd1, "rst_ifw");
    exp_push(S_FLUSH, 8'd0, "rst_flush");
    exp_push(S_FWDA, 8'd0, "rst_fwda");
    exp_push(S_FWDB, 8'd0, "rst_fwdb");
    exp_push(S_EXRW, 8'd0, "rst_exrw");
    exp_push(S_MEMRW, 8'd0, "rst_memrw");
    exp_push(S_WBRW, 8'd0, "rst_wbrw");
    step();
    reset = 1'b0;
    nops(2);

    // Load-use: lw $8,0($9); add $10,$8,$11
    i_lw(5'd8, 5'd9); step();
    i_alu(5'd10, 5'd8, 5'd11);
    exp_push(S_PCW, 8'd0, "lu_pcw");
    exp_push(S_IFW, 8'd0, "lu_ifw");
    exp_push(S_EXMR, 8'd1, "lu_exmr");
    exp_push(S_EXDEST, 8'd8, "lu_exdest");
    step();
    i_alu(5'd10, 5'd8, 5'd11);
    exp_push(S_PCW, 8'd1, "lu_release");
    exp_push(S_EXRW, 8'd0, "lu_bubble");
    exp_push(S_MEMRW, 8'd1, "lu_lw_in_mem");
    step();
    i_nop();
    exp_push(S_FWDA, 8'd1, "lu_fwda_wb");
    exp_push(S_FWDB, 8'd0, "lu_fwdb");
    exp_push(S_EXRW, 8'd1, "lu_add_in_ex");
    step();
    nops(3);

    // Back-to-back ALU: add $3,$1,$2; sub $4,$3,$3
    i_alu(5'd3, 5'd1, 5'd2); step();
    i_alu(5'd4, 5'd3, 5'd3);
    exp_push(S_PCW, 8'd1, "b2b_nostall");
    step();
    i_nop();
    exp_push(S_FWDA, 8'd2, "b2b_fwda");
    exp_push(S_FWDB, 8'd2, "b2b_fwdb");
    step();
    nops(3);

    // Priority and zero: add $3; add $3; or $5,$3,$0
    i_alu(5'd3, 5'd1, 5'd2); step();
    i_alu(5'd3, 5'd1, 5'd2); step();
    i_alu(5'd5, 5'd3, 5'd0); step();
    i_nop();
    exp_push(S_FWDA, 8'd2, "prio_fwda");
    exp_push(S_FWDB, 8'd0, "zero_fwdb");
    step();
    nops(3);

    // Branch after load: lw $2,0($1); beq $2,$0 -> two stall cycles then taken
    i_lw(5'd2, 5'd1); step();
    i_beq(5'd2, 5'd0, 1'b1);
    exp_push(S_PCW, 8'd0, "bl_stall1_pcw");
    exp_push(S_IFW, 8'd0, "bl_stall1_ifw");
    exp_push(S_BT, 8'd0, "bl_stall1_bt");
    exp_push(S_FLUSH, 8'd0, "bl_stall_taken_noflush");
    step();
    i_beq(5'd2, 5'd0, 1'b1);
    exp_push(S_PCW, 8'd0, "bl_stall2_pcw");
    exp_push(S_FLUSH, 8'd0, "bl_stall2_flush");
    step();
    i_beq(5'd2, 5'd0, 1'b1);
    exp_push(S_PCW, 8'd1, "bl_go_pcw");
    exp_push(S_BT, 8'd1, "bl_taken");
    exp_push(S_FLUSH, 8'd1, "bl_flush");
    exp_push(S_FIDA, 8'd0, "bl_fida");
    step();
    i_nop();
    exp_push(S_FLUSH, 8'd0, "bl_flush_once");
    exp_push(S_BT, 8'd0, "bl_bt_once");
    step();
    nops(2);

    // ID forwarding: add $7; nop; beq $7,$5 (not equal)
    i_alu(5'd7, 5'd1, 5'd2); step();
    i_nop(); step();
    i_beq(5'd7, 5'd5, 1'b0);
    exp_push(S_FIDA, 8'd1, "idf_fida");
    exp_push(S_FIDB, 8'd0, "idf_fidb");
    exp_push(S_PCW, 8'd1, "idf_nostall");
    exp_push(S_BT, 8'd0, "idf_bt");
    exp_push(S_FLUSH, 8'd0, "idf_flush");
    step();
    nops(2);

    // Branch after ALU: add $6; bne $6,$1 (equal) -> one stall, not taken
    i_alu(5'd6, 5'd1, 5'd2); step();
    i_bne(5'd6, 5'd1, 1'b1);
    exp_push(S_PCW, 8'd0, "ba_stall");
    step();
    i_bne(5'd6, 5'd1, 1'b1);
    exp_push(S_PCW, 8'd1, "ba_release");
    exp_push(S_BT, 8'd0, "bne_eq_bt");
    exp_push(S_FLUSH, 8'd0, "bne_eq_flush");
    exp_push(S_FIDA, 8'd1, "ba_fida");
    step();
    nops(2);
    i_bne(5'd4, 5'd5, 1'b0);
    exp_push(S_BT, 8'd1, "bne_taken");
    exp_push(S_FLUSH, 8'd1, "bne_flush");
    step();

    // Jump
    i_j();
    exp_push(S_FLUSH, 8'd1, "j_flush");
    exp_push(S_PCW, 8'd1, "j_nostall");
    exp_push(S_BT, 8'd0, "j_bt");
    step();
    nops(2);

    // Reference pass for the reset scenario: lw in EX with add forwarding live
    i_alu(5'd9, 5'd1, 5'd2); step();
    i_alu(5'd9, 5'd1, 5'd2); step();
    i_lw(5'd8, 5'd9); step();
    i_alu(5'd12, 5'd8, 5'd8);
    exp_push(S_EXMR, 8'd1, "pre_exmr");
    exp_push(S_MEMRW, 8'd1, "pre_memrw");
    exp_push(S_WBRW, 8'd1, "pre_wbrw");
    exp_push(S_PCW, 8'd0, "pre_pcw");
    exp_push(S_FWDA, 8'd2, "pre_fwda");
    step();
    nops(3);

    // Same sequence, reset asserted between clock edges
    i_alu(5'd9, 5'd1, 5'd2); step();
    i_alu(5'd9, 5'd1, 5'd2); step();
    i_lw(5'd8, 5'd9); step();
    i_alu(5'd12, 5'd8, 5'd8);
    #1 reset = 1'b1;
    exp_push(S_EXMR, 8'd0, "mrst_exmr");
    exp_push(S_MEMRW, 8'd0, "mrst_memrw");
    exp_push(S_WBRW, 8'd0, "mrst_wbrw");
    exp_push(S_PCW, 8'd1, "mrst_pcw");
    exp_push(S_IFW, 8'd1, "mrst_ifw");
    exp_push(S_FWDA, 8'd0, "mrst_fwda");
    exp_push(S_FLUSH, 8'd0, "mrst_flush");
    step();
    reset = 1'b0;
    nops(3);

    if (sbq.size() != 0) begin
      total += sbq.size();
      bad   += sbq.size();
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Consumer end of the main control decoder's bundle: RegDST, BranchEQ, BranchNE, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, ALUOp, Jump.
- Carries the decoded controls and register indices through the ID/EX, EX/MEM and MEM/WB control registers of the 5-stage pipeline.
- Detects load-use and ID-stage branch hazards, inserting bubbles and stalling PC and IF/ID.
- Produces the EX and ID forwarding selects, and resolves beq/bne/j in ID, generating the IF/ID flush.

Parameters:
- RA_W, 5, register index width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_regdst, id_brancheq, id_branchne, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regwrite, id_jump  in  1 each  decoder outputs for the instruction in ID.
- id_aluop  in  2  decoder ALUOp.
- id_rs, id_rt, id_rd  in  RA_W  instruction fields in ID.
- id_equal  in  1  ID comparator result, after ID forwarding.
- pc_write  out  1  0 = hold PC.
- ifid_write  out  1  0 = hold IF/ID.
- ifid_flush  out  1  1 = IF/ID loads a nop.
- branch_taken  out  1  beq/bne resolved taken.
- ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite  out  1 each  ID/EX control.
- ex_aluop  out  2  ID/EX ALUOp.
- ex_rs, ex_rt, ex_rd  out  RA_W  ID/EX indices.
- ex_dest  out  RA_W  ex_regdst ? ex_rd : ex_rt (combinational).
- mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite  out  1 each  EX/MEM control.
- mem_dest  out  RA_W  EX/MEM destination.
- wb_memtoreg, wb_regwrite  out  1 each  MEM/WB control; memtoreg 1 = ALU result, 0 = memory.
- wb_dest  out  RA_W  MEM/WB destination.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- fwd_id_a, fwd_id_b  out  1  ID comparator operand from EX/MEM result.

Behaviour:
- Reset, asynchronous: all stage registers cleared to 0, i.e. a bubble (no regwrite, no memread/memwrite). This holds mid-operation as well; the effect on the outputs is immediate, not clock-edge-aligned. After reset, stall=0, so pc_write=1, ifid_write=1, ifid_flush=0, fwd_*=0.
- Each clock: MEM/WB <= EX/MEM; EX/MEM <= ID/EX with mem_dest <= ex_dest; ID/EX <= ID inputs, or all-zero controls when stall=1. Indices are copied in either case.
- Latency: each control reaches EX after 1 clock, MEM after 2, WB after 3.
- Index 0 never matches in hazard or forwarding logic.
- id_branch = id_brancheq | id_branchne.
- stall (combinational) is 1 when any of these holds:
  - load-use: ex_memread & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt).
  - branch after ALU op: id_branch & ex_regwrite & ex_dest!=0 & ex_dest matches id_rs or id_rt.
  - branch after load in MEM: id_branch & mem_memread & mem_dest!=0 & mem_dest matches id_rs or id_rt.
- A branch one instruction after a load therefore stalls 2 cycles; a branch one instruction after an ALU op stalls 1 cycle.
- Stall outputs: pc_write = ifid_write = ~stall.
- branch_taken = (id_brancheq & id_equal) | (id_branchne & ~id_equal), gated by ~stall.
- ifid_flush = ~stall & (branch_taken | id_jump). Stall and taken in the same cycle: stall wins and there is no flush; the branch re-resolves in a later cycle.
- Jump never stalls.
- fwd_a:
  - 10 if mem_regwrite & mem_dest!=0 & mem_dest==ex_rs;
  - else 01 if wb_regwrite & wb_dest!=0 & wb_dest==ex_rs;
  - else 00.
  - EX/MEM has priority over MEM/WB.
- fwd_b: same rule against ex_rt.
- fwd_id_a = mem_regwrite & ~mem_memread & mem_dest!=0 & mem_dest==id_rs; fwd_id_b is the same against id_rt.
- Stores, branches and jumps carry regwrite=0 and never create hazards or forwards.

Test Plan:
- Reset asserted mid-stream with a lw in EX -> ex_memread, mem_regwrite and wb_regwrite drop to 0 immediately; pc_write=1 and fwd_a=00 before the next edge.
- Load-use: lw $8,0($9) then add $10,$8,$11 -> one cycle with stall=1 and pc_write=ifid_write=0; ex_regwrite=0 bubble enters EX; two cycles later fwd_a=01.
- Back-to-back ALU forwarding: add $3,$1,$2; sub $4,$3,$3 -> with sub in EX, fwd_a=fwd_b=10; no stall.
- Priority and zero rules: add $3; add $3; or $5,$3,$0 -> with or in EX, fwd_a=10 (not 01), and fwd_b=00 for $0.
- Branch after load: lw $2; beq $2,$0 -> stall held 2 cycles; then, with id_equal=1, branch_taken=1 and ifid_flush=1 for exactly one cycle; fwd_id_a=0 because the value arrives through the regfile.
- Jump and bne: j -> ifid_flush=1, stall=0. bne with id_equal=1 -> branch_taken=0, ifid_flush=0. Branch with stall and taken both true -> ifid_flush=0.
